// File: rtl/dff_pkg.sv
// Shared constants and sizing helpers for the register-pipeline family.
package dff_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Ceiling log2, used to size occupancy counters (clog2(1) = 0).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline stage: data register plus valid bit with reset > flush > enable priority.
module dff_stage
  import dff_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  // A flush drops the valid bit only; the data keeps its value until the next shift.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q       <= RST_VAL;
      q_valid <= 1'b0;
    end else if (clr) begin
      q_valid <= 1'b0;
    end else if (en) begin
      q       <= d;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage data+valid delay line with stall, flush and a registered occupancy count.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int RST_VAL = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic [WIDTH-1:0]             d,
  input  logic                         d_valid,
  output logic [WIDTH-1:0]             q,
  output logic                         q_valid,
  output logic [clog2(DEPTH+1)-1:0]    cnt
);

  localparam int               CW       = clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] RST_DATA = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] s [DEPTH];
  logic             v [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      dff_stage #(.WIDTH(WIDTH), .RST_VAL(RST_DATA)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr),
        .d       (d),
        .d_valid (d_valid),
        .q       (s[i]),
        .q_valid (v[i])
      );
    end else begin : g_body
      dff_stage #(.WIDTH(WIDTH), .RST_VAL(RST_DATA)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (clr),
        .d       (s[i-1]),
        .d_valid (v[i-1]),
        .q       (s[i]),
        .q_valid (v[i])
      );
    end
  end

  // Tracks popcount(v) incrementally: one in at the head, one out at the tail.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(d_valid) - CW'(v[DEPTH-1]);
    end
  end

  assign q       = s[DEPTH-1];
  assign q_valid = v[DEPTH-1];

endmodule

// File: tb/tb_dff_pipe.sv
// Directed self-checking bench for dff_pipe at DEPTH=4 and DEPTH=1, RST_VAL=8'hA5.
module tb_dff_pipe;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic [7:0] d;
  logic       d_valid;

  logic [7:0] q;
  logic       q_valid;
  logic [2:0] cnt;

  logic [7:0] q1;
  logic       q_valid1;
  logic [0:0] cnt1;

  int check_count = 0;
  int pass_count  = 0;

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hA5)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (clr),
    .d       (d),
    .d_valid (d_valid),
    .q       (q),
    .q_valid (q_valid),
    .cnt     (cnt)
  );

  dff_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'hA5)) dut1 (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .clr     (clr),
    .d       (d),
    .d_valid (d_valid),
    .q       (q1),
    .q_valid (q_valid1),
    .cnt     (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; clr = 1'b0; d_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      d = 8'($urandom);
      step();
      check_count++;
      if (q !== 8'hA5) $display("[TB] FAIL reset_q: got %h expected a5", q);
      else pass_count++;
      check_count++;
      if (q_valid !== 1'b0) $display("[TB] FAIL reset_q_valid: got %b expected 0", q_valid);
      else pass_count++;
      check_count++;
      if (cnt !== 3'd0) $display("[TB] FAIL reset_cnt: got %0d expected 0", cnt);
      else pass_count++;
    end
  endtask

  task automatic test_latency();
    logic [7:0] exp_q;
    logic       exp_v;
    logic [2:0] exp_cnt;
    rst = 1'b1; en = 1'b1; clr = 1'b0; d_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      d = 8'(k + 1);
      step();
      exp_q   = (k >= 3) ? 8'(k - 2) : 8'hA5;
      exp_v   = (k >= 3);
      exp_cnt = (k >= 3) ? 3'd4 : 3'(k + 1);
      check_count++;
      if (q !== exp_q) $display("[TB] FAIL latency_q[%0d]: got %h expected %h", k, q, exp_q);
      else pass_count++;
      check_count++;
      if (q_valid !== exp_v) $display("[TB] FAIL latency_q_valid[%0d]: got %b expected %b", k, q_valid, exp_v);
      else pass_count++;
      check_count++;
      if (cnt !== exp_cnt) $display("[TB] FAIL latency_cnt[%0d]: got %0d expected %0d", k, cnt, exp_cnt);
      else pass_count++;
    end
  endtask

  task automatic test_stall();
    en = 1'b0; d = 8'hEE; d_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_count++;
      if (q !== 8'h05 || q_valid !== 1'b1 || cnt !== 3'd4)
        $display("[TB] FAIL stall_hold[%0d]: got q=%h v=%b cnt=%0d expected q=05 v=1 cnt=4", k, q, q_valid, cnt);
      else pass_count++;
    end
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = 8'(9 + k);
      step();
      check_count++;
      if (q !== 8'(6 + k) || q_valid !== 1'b1 || cnt !== 3'd4)
        $display("[TB] FAIL stall_resume[%0d]: got q=%h v=%b cnt=%0d expected q=%h v=1 cnt=4", k, q, q_valid, cnt, 8'(6 + k));
      else pass_count++;
    end
  endtask

  task automatic test_flush();
    logic [7:0] exp_q [4] = '{8'h0A, 8'h0B, 8'h0C, 8'h30};
    clr = 1'b1; en = 1'b1; d = 8'h77; d_valid = 1'b1;
    step();
    check_count++;
    if (q !== 8'h09 || q_valid !== 1'b0 || cnt !== 3'd0)
      $display("[TB] FAIL flush_edge: got q=%h v=%b cnt=%0d expected q=09 v=0 cnt=0", q, q_valid, cnt);
    else pass_count++;
    // The flushed 0x77 must not surface; held data drains out as invalid slots.
    clr = 1'b0; d_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d = 8'(8'h30 + k);
      step();
      check_count++;
      if (q !== exp_q[k] || q_valid !== 1'b0 || cnt !== 3'd0)
        $display("[TB] FAIL flush_drain[%0d]: got q=%h v=%b cnt=%0d expected q=%h v=0 cnt=0", k, q, q_valid, cnt, exp_q[k]);
      else pass_count++;
    end
  endtask

  task automatic test_bubbles();
    logic       dv_pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] exp_q  [8] = '{8'h31, 8'h32, 8'h33, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44};
    logic       exp_v  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0] exp_c  [8] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd2, 3'd2, 3'd1, 3'd0};
    en = 1'b1; clr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      d = 8'(8'h40 + k);
      d_valid = dv_pat[k];
      step();
      check_count++;
      if (q !== exp_q[k] || q_valid !== exp_v[k] || cnt !== exp_c[k])
        $display("[TB] FAIL bubbles[%0d]: got q=%h v=%b cnt=%0d expected q=%h v=%b cnt=%0d",
                 k, q, q_valid, cnt, exp_q[k], exp_v[k], exp_c[k]);
      else pass_count++;
    end
  endtask

  task automatic test_priority();
    en = 1'b1; clr = 1'b0; d = 8'h5A; d_valid = 1'b1;
    step();
    check_count++;
    if (q !== 8'h45 || cnt !== 3'd1)
      $display("[TB] FAIL priority_preload: got q=%h cnt=%0d expected q=45 cnt=1", q, cnt);
    else pass_count++;
    rst = 1'b0; clr = 1'b1; en = 1'b1; d = 8'h66; d_valid = 1'b1;
    step();
    check_count++;
    if (q !== 8'hA5 || q_valid !== 1'b0 || cnt !== 3'd0)
      $display("[TB] FAIL priority_reset: got q=%h v=%b cnt=%0d expected q=a5 v=0 cnt=0", q, q_valid, cnt);
    else pass_count++;
    check_count++;
    if (q1 !== 8'hA5 || q_valid1 !== 1'b0 || cnt1 !== 1'b0)
      $display("[TB] FAIL priority_reset_d1: got q=%h v=%b cnt=%0d expected q=a5 v=0 cnt=0", q1, q_valid1, cnt1);
    else pass_count++;
    rst = 1'b1; clr = 1'b0;
  endtask

  task automatic test_depth1();
    logic [7:0] d_pat  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic       dv_pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    en = 1'b1; clr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      d = d_pat[k];
      d_valid = dv_pat[k];
      step();
      check_count++;
      if (q1 !== d_pat[k] || q_valid1 !== dv_pat[k] || cnt1 !== dv_pat[k])
        $display("[TB] FAIL depth1_follow[%0d]: got q=%h v=%b cnt=%0d expected q=%h v=%b cnt=%0d",
                 k, q1, q_valid1, cnt1, d_pat[k], dv_pat[k], dv_pat[k]);
      else pass_count++;
    end
    en = 1'b0; d = 8'h99; d_valid = 1'b0;
    step();
    check_count++;
    if (q1 !== 8'h44 || q_valid1 !== 1'b1 || cnt1 !== 1'b1)
      $display("[TB] FAIL depth1_stall: got q=%h v=%b cnt=%0d expected q=44 v=1 cnt=1", q1, q_valid1, cnt1);
    else pass_count++;
    clr = 1'b1; en = 1'b1; d = 8'h55; d_valid = 1'b1;
    step();
    check_count++;
    if (q1 !== 8'h44 || q_valid1 !== 1'b0 || cnt1 !== 1'b0)
      $display("[TB] FAIL depth1_flush: got q=%h v=%b cnt=%0d expected q=44 v=0 cnt=0", q1, q_valid1, cnt1);
    else pass_count++;
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; d = 8'h00; d_valid = 1'b0;
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_bubbles();
    test_priority();
    test_depth1();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
